// File: rtl/imem_loader.sv
// imem_loader: loads a little-endian byte stream into instruction memory, then starts the CPU
// Ports:
//   clk_i, rst_i (async, active-high)         clock and reset
//   load_i                                    start a load session (ignored while busy)
//   byte_i, byte_valid_i, byte_ready_o        byte stream handshake
//   imem_we_o, imem_addr_o, imem_data_o       instruction memory write port
//   cpu_start_o                               CPU start, held after a completed session
//   busy_o, words_o, overflow_o               session status
// Build option: define IMEM_LOADER_CLEAR_EN to zero all of memory before each session.
module imem_loader #(
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = 8,
  parameter int BASE_WORD = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              cpu_start_o,
  output logic              busy_o,
  output logic [ADDR_W:0]   words_o,
  output logic              overflow_o
);
`ifdef IMEM_LOADER_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, CLEAR, RECV, DONE} state_t;
  state_t state, state_n;
  logic [1:0] bcnt;
  logic [23:0] shreg;
  logic [31:0] word;
  logic accept, last, term, full, start_req, clear_end;
  always_comb begin
    accept = byte_ready_o && byte_valid_i;
    word = {byte_i, shreg};
    last = accept && bcnt == 2'd3;
    term = word == 32'd0;
    full = words_o == (ADDR_W+1)'(DEPTH-1);
    start_req = (state == IDLE || state == DONE) && load_i;
    clear_end = imem_addr_o == ADDR_W'(DEPTH-1);
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start_req ? (CLEAR_EN ? CLEAR : RECV) : state;
      CLEAR:      state_n = clear_end ? RECV : CLEAR;
      RECV:       state_n = last && (term || full) ? DONE : RECV;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  // Ready and busy are registered from the next state so they never follow byte_valid_i
  // combinationally; busy stays up through the final write cycle so it hands over to start.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      byte_ready_o <= 1'b0;
      imem_we_o <= 1'b0;
      imem_addr_o <= '0;
      imem_data_o <= '0;
      cpu_start_o <= 1'b0;
      busy_o <= 1'b0;
      words_o <= '0;
      overflow_o <= 1'b0;
      bcnt <= '0;
      shreg <= '0;
    end else begin
      imem_we_o <= 1'b0;
      byte_ready_o <= state_n == RECV;
      busy_o <= state_n == CLEAR || state_n == RECV || state == RECV;
      if (start_req) begin
        cpu_start_o <= 1'b0;
        overflow_o <= 1'b0;
        words_o <= '0;
        bcnt <= '0;
        if (CLEAR_EN) begin
          imem_we_o <= 1'b1;
          imem_addr_o <= '0;
          imem_data_o <= '0;
        end
      end else if (state == DONE) begin
        cpu_start_o <= 1'b1;
      end else if (state == CLEAR) begin
        imem_we_o <= !clear_end;
        imem_addr_o <= clear_end ? imem_addr_o : imem_addr_o + 1'b1;
      end else if (accept) begin
        bcnt <= bcnt + 2'd1;
        shreg <= {byte_i, shreg[23:8]};
        if (bcnt == 2'd3) begin
          imem_we_o <= 1'b1;
          imem_addr_o <= ADDR_W'(BASE_WORD) + words_o[ADDR_W-1:0];
          imem_data_o <= word;
          words_o <= words_o + 1'b1;
          overflow_o <= full && !term;
        end
      end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, bvalid = 1'b0;
  logic [7:0] b = 8'h00;
  logic ready, we, start, busy, ovf;
  logic [7:0] addr;
  logic [31:0] data;
  logic [8:0] words;
  int checks = 0, errors = 0, wr_cnt = 0;
  imem_loader dut (
    .clk_i(clk), .rst_i(rst), .load_i(load), .byte_i(b), .byte_valid_i(bvalid),
    .byte_ready_o(ready), .imem_we_o(we), .imem_addr_o(addr), .imem_data_o(data),
    .cpu_start_o(start), .busy_o(busy), .words_o(words), .overflow_o(ovf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (we === 1'b1) wr_cnt <= wr_cnt + 1;
  task automatic do_reset();
    rst = 1'b1; load = 1'b0; bvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic start_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 300 && ready !== 1'b1; i++) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL load_ready got %b exp 1", ready); end
  endtask
  task automatic send_byte(input logic [7:0] v);
    b = v; bvalid = 1'b1;
    @(negedge clk);
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask
  task automatic test_reset();
    int n;
    do_reset();
    checks++; if ({ready, we, addr, data, start, busy, words, ovf} !== 54'd0) begin errors++; $display("FAIL reset_outputs got %h exp 0", {ready, we, addr, data, start, busy, words, ovf}); end
    start_load();
    send_byte(8'hAA); send_byte(8'hBB);
    bvalid = 1'b0; n = wr_cnt;
    rst = 1'b1; #1;
    checks++; if ({ready, we, addr, data, start, busy, words, ovf} !== 54'd0) begin errors++; $display("FAIL reset_mid_recv got %h exp 0", {ready, we, addr, data, start, busy, words, ovf}); end
    @(negedge clk); rst = 1'b0; @(negedge clk);
    checks++; if (wr_cnt !== n) begin errors++; $display("FAIL reset_no_write got %0d exp %0d", wr_cnt, n); end
    start_load();
    send_word(32'h00000001); bvalid = 1'b0;
    checks++; if ({we, addr, data} !== {1'b1, 8'd2, 32'h00000001}) begin errors++; $display("FAIL reset_fresh_session got we=%b addr=%0d data=%h exp we=1 addr=2 data=00000001", we, addr, data); end
  endtask
  task automatic test_basic();
    do_reset();
    start_load();
    send_word(32'h00500013);
    checks++; if ({we, addr, data} !== {1'b1, 8'd2, 32'h00500013}) begin errors++; $display("FAIL basic_w0 got we=%b addr=%0d data=%h exp we=1 addr=2 data=00500013", we, addr, data); end
    send_word(32'h00000000); bvalid = 1'b0;
    checks++; if ({we, addr, data} !== {1'b1, 8'd3, 32'h0}) begin errors++; $display("FAIL basic_w1 got we=%b addr=%0d data=%h exp we=1 addr=3 data=00000000", we, addr, data); end
    checks++; if ({words, ready, busy, start} !== {9'd2, 3'b010}) begin errors++; $display("FAIL basic_write_cycle got words=%0d rdy=%b busy=%b start=%b exp 2 0 1 0", words, ready, busy, start); end
    @(negedge clk);
    checks++; if ({start, busy, we, ready} !== 4'b1000) begin errors++; $display("FAIL basic_start got start/busy/we/rdy=%b exp 1000", {start, busy, we, ready}); end
    repeat (5) @(negedge clk);
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL start_held got %b exp 1", start); end
    load = 1'b1; @(negedge clk); load = 1'b0;
    checks++; if ({start, busy, words} !== {2'b01, 9'd0}) begin errors++; $display("FAIL reload_clears got start=%b busy=%b words=%0d exp 0 1 0", start, busy, words); end
  endtask
  task automatic test_gaps();
    logic [7:0] gb [4];
    int n;
    gb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_reset();
    start_load();
    n = wr_cnt;
    for (int k = 0; k < 4; k++) begin
      send_byte(gb[k]);
      if (k < 3) begin
        bvalid = 1'b0;
        for (int j = 0; j < 3; j++) begin
          checks++; if (we !== 1'b0) begin errors++; $display("FAIL gaps_early_write byte=%0d got we=%b exp 0", k, we); end
          @(negedge clk);
        end
      end
    end
    bvalid = 1'b0;
    checks++; if (wr_cnt !== n) begin errors++; $display("FAIL gaps_write_count got %0d exp %0d", wr_cnt, n); end
    checks++; if ({we, addr, data} !== {1'b1, 8'd2, 32'hDEADBEEF}) begin errors++; $display("FAIL gaps_word got we=%b addr=%0d data=%h exp we=1 addr=2 data=deadbeef", we, addr, data); end
  endtask
  task automatic test_wrap();
    do_reset();
    start_load();
    for (int i = 0; i < 254; i++) begin
      send_word(32'(i + 1));
      if (i == 253) begin
        checks++; if ({we, addr, data} !== {1'b1, 8'd255, 32'd254}) begin errors++; $display("FAIL wrap_w253 got we=%b addr=%0d data=%h exp we=1 addr=255 data=000000fe", we, addr, data); end
      end
    end
    send_word(32'h0); bvalid = 1'b0;
    checks++; if ({we, addr, data} !== {1'b1, 8'd0, 32'd0}) begin errors++; $display("FAIL wrap_term got we=%b addr=%0d data=%h exp we=1 addr=0 data=0", we, addr, data); end
    checks++; if (words !== 9'd255) begin errors++; $display("FAIL wrap_words got %0d exp 255", words); end
    @(negedge clk);
    checks++; if ({start, ovf} !== 2'b10) begin errors++; $display("FAIL wrap_start got start=%b ovf=%b exp 1 0", start, ovf); end
  endtask
  task automatic test_overflow();
    int n;
    do_reset();
    start_load();
    for (int i = 0; i < 256; i++) send_word(32'(i + 1));
    bvalid = 1'b0;
    checks++; if ({we, addr, data} !== {1'b1, 8'd1, 32'd256}) begin errors++; $display("FAIL ovf_last_write got we=%b addr=%0d data=%h exp we=1 addr=1 data=00000100", we, addr, data); end
    checks++; if ({ovf, words, ready} !== {1'b1, 9'd256, 1'b0}) begin errors++; $display("FAIL ovf_flags got ovf=%b words=%0d rdy=%b exp 1 256 0", ovf, words, ready); end
    @(negedge clk);
    checks++; if ({start, ready, busy} !== 3'b100) begin errors++; $display("FAIL ovf_done got start/rdy/busy=%b exp 100", {start, ready, busy}); end
    n = wr_cnt;
    send_word(32'h11223344); bvalid = 1'b0;
    @(negedge clk);
    checks++; if (wr_cnt !== n || words !== 9'd256) begin errors++; $display("FAIL ovf_extra_bytes got writes=%0d words=%0d exp %0d 256", wr_cnt, words, n); end
  endtask
`ifdef IMEM_LOADER_CLEAR_EN
  task automatic test_clear();
    int bad;
    bad = -1;
    do_reset();
    load = 1'b1; @(negedge clk); load = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (bad < 0 && !(we === 1'b1 && addr === 8'(i) && data === 32'd0 && ready === 1'b0 && busy === 1'b1)) bad = i;
      @(negedge clk);
    end
    checks++; if (bad >= 0) begin errors++; $display("FAIL clear_sweep first bad cycle %0d exp we=1 addr=cycle data=0 rdy=0", bad); end
    checks++; if ({ready, we} !== 2'b10) begin errors++; $display("FAIL clear_to_recv got rdy=%b we=%b exp 1 0", ready, we); end
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
`ifdef IMEM_LOADER_CLEAR_EN
    test_clear();
`endif
    test_gaps();
    test_wrap();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Hardware program loader for the RISC-V CPU's instruction memory. Accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit words, and writes them into instruction memory at the rotated word slots fetch expects (first word at index 2, matching the reset PC of 0x10008). Ends on an all-zero terminator word and then raises the CPU start signal. It sits between the host/debug byte source and the `Instruction_Memory` write port, and drives `start_i` of `CPU`.

## Interface
- `DEPTH`, 256, instruction memory depth in words; power of two.
- `ADDR_W`, 8, log2(DEPTH).
- `BASE_WORD`, 2, word index where the first loaded word is written.

- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `load_i`  in  1  single-cycle request to start a load session.
- `byte_i`  in  8  stream byte.
- `byte_valid_i`  in  1  `byte_i` is valid.
- `byte_ready_o`  out  1  loader accepts a byte this cycle.
- `imem_we_o`  out  1  instruction memory write strobe.
- `imem_addr_o`  out  ADDR_W  instruction memory word address.
- `imem_data_o`  out  32  instruction memory write data.
- `cpu_start_o`  out  1  drives CPU `start_i`.
- `busy_o`  out  1  high in CLEAR or RECV.
- `words_o`  out  ADDR_W+1  number of words written this session, terminator included.
- `overflow_o`  out  1  DEPTH words were received without a terminator.

## Operation
- States: IDLE, CLEAR, RECV, DONE.
  - Reset puts the FSM in IDLE.
  - All outputs, the byte counter, the word counter and the assembly register reset to 0.
- IDLE/DONE + `load_i`:
  - clear `cpu_start_o`, `overflow_o`, `words_o` and the byte counter;
  - go to CLEAR if the clear feature is compiled in, otherwise go to RECV.
- `load_i` during CLEAR or RECV is ignored.
- CLEAR:
  - write 0 to addresses 0..DEPTH-1 in ascending order, one per cycle;
  - `byte_ready_o` is 0;
  - after address DEPTH-1, go to RECV.
- RECV:
  - `byte_ready_o` is 1.
  - A byte is accepted on each cycle where `byte_valid_i` and `byte_ready_o` are both high.
  - Bytes fill the word LSB first (byte 0 goes to bits [7:0]).
  - On the 4th accepted byte, the word is written to address (BASE_WORD + words) & (DEPTH-1), and `words_o` increments.
  - Word index DEPTH-BASE_WORD wraps to address 0.
- Terminator: an assembled word equal to 0 is still written. It is counted, and the FSM goes to DONE.
- Overflow: when `words_o` reaches DEPTH with no terminator:
  - set `overflow_o`, go to DONE;
  - `byte_ready_o` drops immediately, so no further write can occur.
- DONE:
  - `cpu_start_o` = 1 and is held until `load_i` or `rst_i`;
  - `byte_ready_o` = 0.
- Reset during any state aborts the session. A partially assembled word is discarded and never written.

## Timing
- All outputs are registered.
- `byte_ready_o` is a function of state only. It never depends combinationally on `byte_valid_i`.
- Write latency: `imem_we_o` is high for exactly 1 cycle, the cycle after the 4th byte handshake, with `imem_addr_o`/`imem_data_o` valid in that cycle.
- `imem_addr_o`/`imem_data_o` hold their last values when `imem_we_o` is low.
- Throughput: 1 byte per cycle sustained; 4 cycles per word.
- `cpu_start_o` rises the cycle after the terminator or overflow-causing write.
- CLEAR lasts exactly DEPTH cycles, with `imem_we_o` high in every one of them.
- `busy_o` is high from the cycle after `load_i` until the cycle `cpu_start_o` rises. The two are never high together.

## Configuration
- `IMEM_LOADER_CLEAR_EN`
  - Defined: the CLEAR state exists. Every session zeroes all of memory before RECV, so stale code past the terminator is removed.
  - Undefined: `load_i` goes straight to RECV, and locations not rewritten keep their old contents.

## Test plan
- Reset mid-RECV after 2 bytes -> all outputs are 0, state is IDLE, no write occurs. A following `load_i` starts a fresh session at address 2.
- Macro undefined; `load_i`, then bytes 13 00 50 00 00 00 00 00 back-to-back ->
  - write addr 2 data 0x00500013;
  - write addr 3 data 0x00000000;
  - `words_o`=2;
  - `cpu_start_o`=1 the cycle after the second write.
- Macro defined; `load_i` -> 256 consecutive writes of 0 to addresses 0..255 with `byte_ready_o`=0, then `byte_ready_o`=1.
- Bytes EF BE AD DE with `byte_valid_i` idle for 3 cycles between each -> one write of 0xDEADBEEF at addr 2; no write before the 4th byte.
- 254 nonzero words, then a zero word ->
  - word 253 goes to addr 255;
  - the terminator goes to addr 0;
  - `words_o`=255.
- 256 nonzero words -> `overflow_o`=1, `words_o`=256, `cpu_start_o`=1, `byte_ready_o`=0; extra bytes are not accepted and cause no write.
